// File: rtl/bp_cacc_pkg.sv
// -----------------------------------------------------------------------------
// bp_cacc_pkg
// Shared definitions for the vector dot-product/sum accelerator:
//   - CSR byte offsets of the MMIO register map
//   - engine state enum (bp_cacc_vdp_state_e)
//   - operation enum (bp_cacc_op_e)
//   - misaligned(): element-alignment test for pointer CSRs
// -----------------------------------------------------------------------------
package bp_cacc_pkg;

    localparam logic [7:0] CSR_A_PTR   = 8'h00;
    localparam logic [7:0] CSR_B_PTR   = 8'h08;
    localparam logic [7:0] CSR_LEN     = 8'h10;
    localparam logic [7:0] CSR_START   = 8'h18;
    localparam logic [7:0] CSR_STATUS  = 8'h20;
    localparam logic [7:0] CSR_RES_PTR = 8'h28;
    localparam logic [7:0] CSR_OP      = 8'h30;
    localparam logic [7:0] CSR_RESULT  = 8'h38;
    localparam logic [7:0] CSR_CYCLES  = 8'h40;
    localparam logic [7:0] CSR_REQS    = 8'h48;

    typedef enum logic [2:0] {
        e_idle,
        e_load_a,
        e_load_b,
        e_reduce,
        e_store,
        e_done
    } bp_cacc_vdp_state_e;

    typedef enum logic {
        e_cacc_op_dot = 1'b0,
        e_cacc_op_sum = 1'b1
    } bp_cacc_op_e;

    // True when addr is not a multiple of bytes (bytes is a power of two).
    function automatic logic misaligned(input logic [63:0] addr, input int unsigned bytes);
        return (addr & (64'(bytes) - 64'd1)) != 64'd0;
    endfunction

endpackage

// File: rtl/bp_cacc_reduce_tree.sv
// -----------------------------------------------------------------------------
// bp_cacc_reduce_tree
// Combinational reduction of one chunk: forms lanes_p lane terms (a*b or a+b,
// each truncated to 64 bits) and sums them through log2(lanes_p) adder levels.
// Ports:
//   a, b  in  lanes_p x 64  operand lanes (unused lanes are zero)
//   op    in  bp_cacc_op_e  e_cacc_op_dot -> products, e_cacc_op_sum -> sums
//   sum   out 64            sum of all lane terms, mod 2^64
// -----------------------------------------------------------------------------
module bp_cacc_reduce_tree
    import bp_cacc_pkg::*;
#(
    parameter int lanes_p = 8
) (
    input  logic [lanes_p-1:0][63:0] a,
    input  logic [lanes_p-1:0][63:0] b,
    input  bp_cacc_op_e              op,
    output logic [63:0]              sum
);

    localparam int LEVELS = $clog2(lanes_p);

    // lvl[l][i]: node i of level l; level 0 holds the lane terms.
    logic [63:0] lvl [0:LEVELS][0:lanes_p-1];

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            for (int i = 0; i < lanes_p; i++) begin
                lvl[l][i] = '0;
            end
        end
        for (int i = 0; i < lanes_p; i++) begin
            lvl[0][i] = (op == e_cacc_op_sum) ? a[i] + b[i] : a[i] * b[i];
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < lanes_p / 2; i++) begin
                if (i < (lanes_p >> (l + 1))) begin
                    lvl[l+1][i] = lvl[l][2*i] + lvl[l][2*i+1];
                end
            end
        end
    end

    assign sum = lvl[LEVELS][0];

endmodule

// File: rtl/bp_cacc_vdp_multilane.sv
// -----------------------------------------------------------------------------
// bp_cacc_vdp_multilane
// Vector dot-product / sum engine. Software programs the CSRs, the engine
// fetches A and B a chunk of lanes_p elements at a time over a single-
// outstanding memory port, reduces each chunk, accumulates across chunks and
// stores the 64-bit result to res_ptr.
// Optional feature macro: BP_CACC_VDP_PERF_EN (busy-cycle and request counters
// at CSR 0x40 / 0x48; when undefined those offsets read 0).
// Ports:
//   clk_i, reset_i                   clock, synchronous active-high reset
//   csr_w_v_i/csr_r_v_i              CSR write / read strobes
//   csr_addr_i, csr_data_i           CSR byte offset, write data
//   csr_data_o, csr_r_v_o            read data and its 1-cycle valid
//   mem_req_v_o, mem_req_ready_i     memory request handshake
//   mem_req_we_o/addr_o/data_o       request fields (1 = store)
//   mem_resp_v_i, mem_resp_data_i    response strobe and load data
//   done_o                           status.done level
// -----------------------------------------------------------------------------
module bp_cacc_vdp_multilane
    import bp_cacc_pkg::*;
#(
    parameter int lanes_p       = 8,
    parameter int elem_width_p  = 64,
    parameter int len_width_p   = 16,
    parameter int paddr_width_p = 40
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     csr_w_v_i,
    input  logic                     csr_r_v_i,
    input  logic [7:0]               csr_addr_i,
    input  logic [63:0]              csr_data_i,
    output logic [63:0]              csr_data_o,
    output logic                     csr_r_v_o,
    output logic                     mem_req_v_o,
    input  logic                     mem_req_ready_i,
    output logic                     mem_req_we_o,
    output logic [paddr_width_p-1:0] mem_req_addr_o,
    output logic [63:0]              mem_req_data_o,
    input  logic                     mem_resp_v_i,
    input  logic [63:0]              mem_resp_data_i,
    output logic                     done_o
);

    localparam int KW         = $clog2(lanes_p) + 1;
    localparam int ELEM_BYTES = elem_width_p / 8;
    localparam int ELEM_SHIFT = $clog2(ELEM_BYTES);

    bp_cacc_vdp_state_e state, state_next;

    logic [paddr_width_p-1:0] a_ptr, b_ptr, res_ptr;
    logic [len_width_p-1:0]   len, idx, rem, idx_next;
    logic [63:0]              op_csr, result, acc, tree_sum, rd_mux;
    logic                     done, err, busy, wait_resp;
    logic [KW-1:0]            k, n;
    logic [lanes_p-1:0][63:0] buf_a, buf_b;
    logic [paddr_width_p-1:0] elem_off;
    logic start_go, start_bad, start_ok;
    logic fire, resp_ok, load_idle, chunk_loaded, in_load;
    logic unused_resp_hi;

    // Upper response bits beyond the element width are intentionally ignored.
    assign unused_resp_hi = ^mem_resp_data_i;

    assign start_go  = csr_w_v_i & (csr_addr_i == CSR_START) & csr_data_i[0] & ~busy;
    assign start_bad = (op_csr > 64'd1)
                     | misaligned(64'(a_ptr), ELEM_BYTES)
                     | misaligned(64'(b_ptr), ELEM_BYTES)
                     | misaligned(64'(res_ptr), ELEM_BYTES);
    assign start_ok  = start_go & ~start_bad;

    // Elements left and size of the current chunk; idx+n never exceeds len.
    assign rem      = len - idx;
    assign n        = (rem >= len_width_p'(lanes_p)) ? KW'(lanes_p) : KW'(rem);
    assign idx_next = idx + len_width_p'(n);

    assign fire         = mem_req_v_o & mem_req_ready_i;
    assign resp_ok      = wait_resp & mem_resp_v_i;
    assign in_load      = (state == e_load_a) | (state == e_load_b);
    assign load_idle    = ~mem_req_v_o & ~wait_resp;
    assign chunk_loaded = load_idle & (k == n);
    assign elem_off     = (paddr_width_p'(idx) + paddr_width_p'(k)) << ELEM_SHIFT;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= e_idle;
        else         state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            e_idle, e_done: begin
                if (start_ok) state_next = (len == '0) ? e_store : e_load_a;
                else          state_next = e_idle;
            end
            e_load_a: if (chunk_loaded) state_next = e_load_b;
            e_load_b: if (chunk_loaded) state_next = e_reduce;
            e_reduce: state_next = (idx_next < len) ? e_load_a : e_store;
            e_store:  if (resp_ok) state_next = e_done;
            default:  state_next = e_idle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == e_load_a) | (state == e_load_b)
             | (state == e_reduce) | (state == e_store);
    end

    assign done_o = done;

    // ---------------- control: CSRs, indices, memory port ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            a_ptr          <= '0;
            b_ptr          <= '0;
            res_ptr        <= '0;
            len            <= '0;
            op_csr         <= '0;
            result         <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
            idx            <= '0;
            k              <= '0;
            wait_resp      <= 1'b0;
            mem_req_v_o    <= 1'b0;
            mem_req_we_o   <= 1'b0;
            mem_req_addr_o <= '0;
            mem_req_data_o <= '0;
        end else begin
            if (csr_w_v_i & ~busy) begin
                case (csr_addr_i)
                    CSR_A_PTR:   a_ptr   <= csr_data_i[paddr_width_p-1:0];
                    CSR_B_PTR:   b_ptr   <= csr_data_i[paddr_width_p-1:0];
                    CSR_LEN:     len     <= csr_data_i[len_width_p-1:0];
                    CSR_RES_PTR: res_ptr <= csr_data_i[paddr_width_p-1:0];
                    CSR_OP:      op_csr  <= csr_data_i;
                    default: ;
                endcase
            end

            if (fire) begin
                mem_req_v_o <= 1'b0;
                wait_resp   <= 1'b1;
            end

            if (resp_ok) begin
                wait_resp <= 1'b0;
                if (in_load) k <= k + KW'(1);
                if (state == e_store) begin
                    result <= acc;
                    done   <= 1'b1;
                end
            end

            // Issue the next load of the chunk, or the result store.
            if (load_idle & in_load & (k < n)) begin
                mem_req_v_o    <= 1'b1;
                mem_req_we_o   <= 1'b0;
                mem_req_addr_o <= ((state == e_load_a) ? a_ptr : b_ptr) + elem_off;
                mem_req_data_o <= '0;
            end else if (load_idle & (state == e_store)) begin
                mem_req_v_o    <= 1'b1;
                mem_req_we_o   <= 1'b1;
                mem_req_addr_o <= res_ptr;
                mem_req_data_o <= acc;
            end

            if (in_load & chunk_loaded) k <= '0;
            if (state == e_reduce)      idx <= idx_next;

            if (start_go) begin
                if (start_bad) begin
                    err <= 1'b1;
                end else begin
                    done <= 1'b0;
                    idx  <= '0;
                    k    <= '0;
                end
            end

            // Status writes clear the sticky flags, even while busy.
            if (csr_w_v_i & (csr_addr_i == CSR_STATUS)) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
        end
    end

    // ---------------- datapath: chunk buffers and accumulator ----------------
    always_ff @(posedge clk_i) begin
        if ((state_next == e_load_a) & (state != e_load_a)) begin
            buf_a <= '0;
            buf_b <= '0;
        end
        if (resp_ok & (state == e_load_a)) buf_a[k[KW-2:0]] <= 64'(mem_resp_data_i[elem_width_p-1:0]);
        if (resp_ok & (state == e_load_b)) buf_b[k[KW-2:0]] <= 64'(mem_resp_data_i[elem_width_p-1:0]);
        if (start_ok)                 acc <= '0;
        else if (state == e_reduce)   acc <= acc + tree_sum;
    end

    bp_cacc_reduce_tree #(
        .lanes_p (lanes_p)
    ) u_tree (
        .a   (buf_a),
        .b   (buf_b),
        .op  (bp_cacc_op_e'(op_csr[0])),
        .sum (tree_sum)
    );

`ifdef BP_CACC_VDP_PERF_EN
    logic [63:0] perf_cycles, perf_reqs;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_cycles <= '0;
            perf_reqs   <= '0;
        end else if (start_ok) begin
            perf_cycles <= '0;
            perf_reqs   <= '0;
        end else begin
            if (busy) perf_cycles <= perf_cycles + 64'd1;
            if (fire) perf_reqs   <= perf_reqs + 64'd1;
        end
    end
`endif

    // ---------------- CSR read path ----------------
    always_comb begin
        rd_mux = '0;
        case (csr_addr_i)
            CSR_A_PTR:   rd_mux = 64'(a_ptr);
            CSR_B_PTR:   rd_mux = 64'(b_ptr);
            CSR_LEN:     rd_mux = 64'(len);
            CSR_STATUS:  rd_mux = {61'd0, err, done, busy};
            CSR_RES_PTR: rd_mux = 64'(res_ptr);
            CSR_OP:      rd_mux = op_csr;
            CSR_RESULT:  rd_mux = result;
`ifdef BP_CACC_VDP_PERF_EN
            CSR_CYCLES:  rd_mux = perf_cycles;
            CSR_REQS:    rd_mux = perf_reqs;
`endif
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            csr_r_v_o  <= 1'b0;
            csr_data_o <= '0;
        end else begin
            csr_r_v_o  <= csr_r_v_i;
            csr_data_o <= csr_r_v_i ? rd_mux : 64'd0;
        end
    end

endmodule

// File: tb/tb_bp_cacc_vdp_multilane.sv
module tb_bp_cacc_vdp_multilane;
    import bp_cacc_pkg::*;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        csr_w_v_i, csr_r_v_i;
    logic [7:0]  csr_addr_i;
    logic [63:0] csr_data_i, csr_data_o;
    logic        csr_r_v_o;
    logic        mem_req_v_o, mem_req_ready_i, mem_req_we_o;
    logic [39:0] mem_req_addr_o;
    logic [63:0] mem_req_data_o;
    logic        mem_resp_v_i;
    logic [63:0] mem_resp_data_i;
    logic        done_o;

    always #5 clk = ~clk;

    bp_cacc_vdp_multilane #(
        .lanes_p(8), .elem_width_p(64), .len_width_p(16), .paddr_width_p(40)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .csr_w_v_i(csr_w_v_i), .csr_r_v_i(csr_r_v_i), .csr_addr_i(csr_addr_i),
        .csr_data_i(csr_data_i), .csr_data_o(csr_data_o), .csr_r_v_o(csr_r_v_o),
        .mem_req_v_o(mem_req_v_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_data_o(mem_req_data_o), .mem_resp_v_i(mem_resp_v_i),
        .mem_resp_data_i(mem_resp_data_i), .done_o(done_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model / responder ----------------
    logic [63:0] mem [logic [39:0]];
    bit          pending, resp_now, fire, prev_hold, rand_ready;
    int          cd, stall_cycles, force_delay, rand_delay;
    int          req_cnt, store_cnt, overlap_err, stab_err;
    logic [39:0] p_addr, prev_addr, last_fire_addr;
    logic        p_we, prev_we;
    logic [63:0] prev_data;

    function automatic logic [63:0] mem_rd(input logic [39:0] a);
        if (mem.exists(a)) return mem[a];
        return 64'd0;
    endfunction

    initial begin : responder
        mem_resp_v_i = 0; mem_resp_data_i = 0; mem_req_ready_i = 1;
        pending = 0; prev_hold = 0; cd = 0;
        stall_cycles = 0; force_delay = -1; rand_delay = 0; rand_ready = 0;
        req_cnt = 0; store_cnt = 0; overlap_err = 0; stab_err = 0;
        last_fire_addr = '0;
        forever begin
            @(negedge clk);
            mem_resp_v_i = 0;
            resp_now = 0;
            if (pending) begin
                if (cd == 0) begin
                    mem_resp_v_i    = 1;
                    mem_resp_data_i = p_we ? 64'd0 : mem_rd(p_addr);
                    resp_now        = 1;
                end else begin
                    cd--;
                end
            end
            if (stall_cycles > 0) begin
                mem_req_ready_i = 0;
                stall_cycles--;
            end else if (rand_ready) begin
                mem_req_ready_i = 1'($urandom_range(0, 1));
            end else begin
                mem_req_ready_i = 1;
            end
            if (!reset_i && prev_hold) begin
                if (!mem_req_v_o || mem_req_addr_o !== prev_addr ||
                    mem_req_we_o !== prev_we || mem_req_data_o !== prev_data)
                    stab_err++;
            end
            fire = mem_req_v_o && mem_req_ready_i && !reset_i;
            if (fire) begin
                if (pending) overlap_err++;
                p_addr = mem_req_addr_o;
                p_we   = mem_req_we_o;
                cd     = (force_delay >= 0) ? force_delay :
                         (rand_delay != 0) ? int'($urandom_range(0, 4)) : 0;
                req_cnt++;
                last_fire_addr = mem_req_addr_o;
                if (mem_req_we_o) begin
                    mem[mem_req_addr_o] = mem_req_data_o;
                    store_cnt++;
                end
            end
            if (resp_now) pending = 0;
            if (fire) pending = 1;
            prev_hold = mem_req_v_o && !mem_req_ready_i && !reset_i;
            prev_addr = mem_req_addr_o;
            prev_we   = mem_req_we_o;
            prev_data = mem_req_data_o;
        end
    end

    // ---------------- CSR / job helpers ----------------
    logic [63:0] rd;

    task automatic csr_wr(input logic [7:0] a, input logic [63:0] d);
        @(negedge clk);
        csr_w_v_i = 1; csr_addr_i = a; csr_data_i = d;
        @(negedge clk);
        csr_w_v_i = 0;
    endtask

    task automatic csr_rd(input string tag, input logic [7:0] a, input logic [63:0] exp);
        @(negedge clk);
        csr_r_v_i = 1; csr_addr_i = a;
        @(negedge clk);
        csr_r_v_i = 0;
        check_eq({tag, "_rv"}, 64'(csr_r_v_o), 64'd1);
        check_eq(tag, csr_data_o, exp);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) break;
        end
        if (i == budget) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic setup_job(input logic [39:0] a, input logic [39:0] b, input logic [15:0] n,
                             input logic [39:0] r, input logic [63:0] op);
        csr_wr(CSR_STATUS, 64'd0);
        csr_wr(CSR_A_PTR, 64'(a));
        csr_wr(CSR_B_PTR, 64'(b));
        csr_wr(CSR_LEN, 64'(n));
        csr_wr(CSR_RES_PTR, 64'(r));
        csr_wr(CSR_OP, op);
        req_cnt = 0; store_cnt = 0;
    endtask

    task automatic check_reqs(input string tag, input int exp);
        check_eq({tag, "_reqs"}, 64'(req_cnt), 64'(exp));
`ifdef BP_CACC_VDP_PERF_EN
        csr_rd({tag, "_perf_reqs"}, CSR_REQS, 64'(exp));
`else
        csr_rd({tag, "_perf_reqs"}, CSR_REQS, 64'd0);
`endif
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int i;
        csr_w_v_i = 0; csr_r_v_i = 0; csr_addr_i = 0; csr_data_i = 0;
        reset_i = 1;
        repeat (3) @(negedge clk);
        check_eq("rst_req_v", 64'(mem_req_v_o), 64'd0);
        check_eq("rst_done", 64'(done_o), 64'd0);
        check_eq("rst_r_v", 64'(csr_r_v_o), 64'd0);
        check_eq("rst_addr", 64'(mem_req_addr_o), 64'd0);
        reset_i = 0;
        csr_rd("rst_status", CSR_STATUS, 64'd0);
        csr_rd("rst_a_ptr", CSR_A_PTR, 64'd0);

        // Test 1: one full chunk, dot product
        for (i = 0; i < 8; i++) begin
            mem[40'h1000 + 40'(8*i)] = 64'(i + 1);
            mem[40'h2000 + 40'(8*i)] = 64'd2;
        end
        setup_job(40'h1000, 40'h2000, 16'd8, 40'h3000, 64'd0);
        csr_wr(CSR_START, 64'd1);
        wait_done("t1", 500);
        check_eq("t1_done_o", 64'(done_o), 64'd1);
        csr_rd("t1_result", CSR_RESULT, 64'd72);
        check_eq("t1_mem", mem_rd(40'h3000), 64'd72);
        check_eq("t1_stores", 64'(store_cnt), 64'd1);
        check_reqs("t1", 17);
        csr_rd("t1_status", CSR_STATUS, 64'd2);
        csr_rd("t1_start_rd", CSR_START, 64'd0);
        csr_wr(CSR_STATUS, 64'd0);
        check_eq("t1_done_clr", 64'(done_o), 64'd0);

        // Test 2: two chunks, second partial
        for (i = 0; i < 11; i++) begin
            mem[40'h4000 + 40'(8*i)] = 64'(i + 1);
            mem[40'h5000 + 40'(8*i)] = 64'(i + 1);
        end
        setup_job(40'h4000, 40'h5000, 16'd11, 40'h3008, 64'd0);
        csr_wr(CSR_START, 64'd1);
        wait_done("t2", 800);
        csr_rd("t2_result", CSR_RESULT, 64'd506);
        check_eq("t2_mem", mem_rd(40'h3008), 64'd506);
        check_reqs("t2", 23);

        // Test 3: sum op, config write and start while busy are ignored
        for (i = 0; i < 5; i++) begin
            mem[40'h6000 + 40'(8*i)] = 64'd10;
            mem[40'h7000 + 40'(8*i)] = 64'd10;
        end
        setup_job(40'h6000, 40'h7000, 16'd5, 40'h3010, 64'd1);
        csr_wr(CSR_START, 64'd1);
        csr_wr(CSR_LEN, 64'd2);
        csr_wr(CSR_START, 64'd1);
        wait_done("t3", 500);
        csr_rd("t3_result", CSR_RESULT, 64'd100);
        csr_rd("t3_len", CSR_LEN, 64'd5);
        check_reqs("t3", 11);

        // Test 4: zero length, then illegal op and misaligned pointer
        mem[40'h3018] = 64'hDEAD;
        setup_job(40'h6000, 40'h7000, 16'd0, 40'h3018, 64'd0);
        csr_wr(CSR_START, 64'd1);
        wait_done("t4", 100);
        check_eq("t4_mem", mem_rd(40'h3018), 64'd0);
        csr_rd("t4_result", CSR_RESULT, 64'd0);
        check_reqs("t4", 1);
        setup_job(40'h1000, 40'h2000, 16'd4, 40'h3020, 64'd3);
        csr_wr(CSR_START, 64'd1);
        repeat (10) @(negedge clk);
        csr_rd("t4_op_err", CSR_STATUS, 64'd4);
        check_eq("t4_op_reqs", 64'(req_cnt), 64'd0);
        setup_job(40'h1004, 40'h2000, 16'd4, 40'h3020, 64'd0);
        csr_wr(CSR_START, 64'd1);
        repeat (10) @(negedge clk);
        csr_rd("t4_align_err", CSR_STATUS, 64'd4);
        check_eq("t4_align_reqs", 64'(req_cnt), 64'd0);

        // Test 5: backpressure, random delays, 64-bit wrap
        mem[40'h8000] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[40'h9000] = 64'd2;
        setup_job(40'h8000, 40'h9000, 16'd1, 40'h3028, 64'd0);
        overlap_err = 0; stab_err = 0; rand_delay = 1;
        stall_cycles = 8;
        csr_wr(CSR_START, 64'd1);
        wait_done("t5", 500);
        csr_rd("t5_result", CSR_RESULT, 64'hFFFF_FFFF_FFFF_FFFE);
        check_reqs("t5", 3);
        rand_ready = 1;
        setup_job(40'h4000, 40'h5000, 16'd11, 40'h3030, 64'd0);
        csr_wr(CSR_START, 64'd1);
        wait_done("t5b", 3000);
        rand_ready = 0; rand_delay = 0;
        csr_rd("t5b_result", CSR_RESULT, 64'd506);
        check_eq("t5_overlap", 64'(overlap_err), 64'd0);
        check_eq("t5_stable", 64'(stab_err), 64'd0);

        // Test 6: reset while a B load is outstanding
        setup_job(40'h1000, 40'h2000, 16'd8, 40'h3038, 64'd0);
        force_delay = 8;
        last_fire_addr = '0;
        csr_wr(CSR_START, 64'd1);
        for (i = 0; i < 500; i++) begin
            @(negedge clk);
            if (last_fire_addr == 40'h2000) break;
        end
        if (i == 500) check_eq("t6_fire_timeout", 64'd0, 64'd1);
        @(negedge clk);
        reset_i = 1;
        @(negedge clk);
        @(negedge clk);
        check_eq("t6_req_v", 64'(mem_req_v_o), 64'd0);
        check_eq("t6_done", 64'(done_o), 64'd0);
        reset_i = 0;
        repeat (12) @(negedge clk);
        force_delay = -1;
        csr_rd("t6_status", CSR_STATUS, 64'd0);
        csr_rd("t6_a_ptr", CSR_A_PTR, 64'd0);
        setup_job(40'h1000, 40'h2000, 16'd8, 40'h3040, 64'd0);
        overlap_err = 0;
        csr_wr(CSR_START, 64'd1);
        wait_done("t6", 500);
        csr_rd("t6_result", CSR_RESULT, 64'd72);
        check_eq("t6_mem", mem_rd(40'h3040), 64'd72);
        check_eq("t6_overlap", 64'(overlap_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
